// File: rtl/sample_delay_pkg.sv
// Shared types and constants for the multi-channel sample delay.
// Optional fractional (half-sample) delay is enabled by defining SAMPLE_DELAY_FRAC_EN.
package sample_delay_pkg;

   localparam int DEF_WIDTH    = 16;
   localparam int DEF_DEPTH    = 256;
   localparam int DEF_CHANNELS = 4;

   typedef logic signed [DEF_WIDTH-1:0] sample_t;

   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/sample_delay_lane.sv
// One channel of the sample delay: circular buffer, delay/fill registers, registered output.
// SAMPLE_DELAY_FRAC_EN adds a half-sample interpolated mode selected by i_frac.
module sample_delay_lane
   import sample_delay_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int DEPTH = DEF_DEPTH,
   localparam int AW    = addr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_din_valid,
   input  logic             i_delay_load,
   input  logic [AW-1:0]    i_wp,
   input  logic [WIDTH-1:0] i_din,
   input  logic [AW-1:0]    i_delay,
`ifdef SAMPLE_DELAY_FRAC_EN
   input  logic             i_frac,
`endif
   output logic [WIDTH-1:0] o_dout,
   output logic             o_dout_valid
);

   localparam logic [AW-1:0] MAX_FB = AW'(DEPTH - 1);
   localparam logic [AW-1:0] ONE    = AW'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_delay;
   logic [AW-1:0]    r_fb;
   logic [WIDTH-1:0] r_dout;
   logic             r_valid;

   logic [AW-1:0]    w_d;
   logic [AW-1:0]    w_fb;
   logic [AW-1:0]    w_raddr;
   logic [WIDTH-1:0] w_near;
   logic [WIDTH-1:0] w_out;
   logic             w_ok;

`ifdef SAMPLE_DELAY_FRAC_EN
   logic             r_frac;
   logic             w_frac;
   logic [WIDTH-1:0] w_older;
   logic [WIDTH:0]   w_sum;
`endif

   // A load in the same cycle as a sample takes effect for that sample with an empty fill.
   always_comb begin
      w_d     = i_delay_load ? i_delay : r_delay;
      w_fb    = i_delay_load ? '0 : r_fb;
      w_raddr = i_wp - w_d;
      w_near  = (w_d == '0) ? i_din : r_mem[w_raddr];
      w_out   = w_near;
      w_ok    = (w_fb >= w_d);
`ifdef SAMPLE_DELAY_FRAC_EN
      w_frac  = (i_delay_load ? i_frac : r_frac) && (w_d != MAX_FB);
      w_older = r_mem[w_raddr - ONE];
      w_sum   = {w_near[WIDTH-1], w_near} + {w_older[WIDTH-1], w_older};
      if (w_frac) begin
         w_out = w_sum[WIDTH:1];
         w_ok  = (w_fb > w_d);
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (i_din_valid) begin
         r_mem[i_wp] <= i_din;
      end
   end

   // dout only moves on a valid output, so stale buffer contents never reach the port.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_delay <= '0;
         r_fb    <= '0;
         r_dout  <= '0;
         r_valid <= 1'b0;
`ifdef SAMPLE_DELAY_FRAC_EN
         r_frac  <= 1'b0;
`endif
      end else begin
         if (i_delay_load) begin
            r_delay <= i_delay;
`ifdef SAMPLE_DELAY_FRAC_EN
            r_frac  <= i_frac;
`endif
         end
         if (i_din_valid) begin
            r_valid <= w_ok;
            if (w_ok) begin
               r_dout <= w_out;
            end
            r_fb <= (w_fb == MAX_FB) ? MAX_FB : w_fb + ONE;
         end else begin
            r_valid <= 1'b0;
            if (i_delay_load) begin
               r_fb <= '0;
            end
         end
      end
   end

   assign o_dout       = r_dout;
   assign o_dout_valid = r_valid;

endmodule

// File: rtl/multi_channel_sample_delay.sv
// Multi-channel programmable sample delay sharing one write pointer across per-channel lanes.
// Define SAMPLE_DELAY_FRAC_EN to add the delay_frac half-sample interpolation input.
module multi_channel_sample_delay
   import sample_delay_pkg::*;
#(
   parameter  int WIDTH    = DEF_WIDTH,
   parameter  int DEPTH    = DEF_DEPTH,
   parameter  int CHANNELS = DEF_CHANNELS,
   localparam int AW       = addr_width(DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   din_valid,
   input  logic [CHANNELS*WIDTH-1:0] din,
   input  logic [CHANNELS*AW-1:0] delay,
   input  logic                   delay_load,
`ifdef SAMPLE_DELAY_FRAC_EN
   input  logic [CHANNELS-1:0]    delay_frac,
`endif
   output logic [CHANNELS*WIDTH-1:0] dout,
   output logic [CHANNELS-1:0]    dout_valid
);

   logic [AW-1:0] r_wp;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wp <= '0;
      end else if (din_valid) begin
         r_wp <= r_wp + AW'(1);
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      sample_delay_lane #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_lane (
         .clk          (clk),
         .reset        (reset),
         .i_din_valid  (din_valid),
         .i_delay_load (delay_load),
         .i_wp         (r_wp),
         .i_din        (din[g*WIDTH +: WIDTH]),
         .i_delay      (delay[g*AW +: AW]),
`ifdef SAMPLE_DELAY_FRAC_EN
         .i_frac       (delay_frac[g]),
`endif
         .o_dout       (dout[g*WIDTH +: WIDTH]),
         .o_dout_valid (dout_valid[g])
      );
   end

endmodule

// File: tb/tb_multi_channel_sample_delay.sv
// Self-checking bench for multi_channel_sample_delay: history-based model plus directed literal checks.
module tb_multi_channel_sample_delay;

   localparam int W     = 16;
   localparam int DEPTH = 256;
   localparam int CH    = 4;
   localparam int AW    = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic              din_valid;
   logic              delay_load;
   logic [CH*W-1:0]   din;
   logic [CH*AW-1:0]  delay;
`ifdef SAMPLE_DELAY_FRAC_EN
   logic [CH-1:0]     delay_frac;
`endif
   logic [CH*W-1:0]   dout;
   logic [CH-1:0]     dout_valid;

   multi_channel_sample_delay #(
      .WIDTH    (W),
      .DEPTH    (DEPTH),
      .CHANNELS (CH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .din_valid  (din_valid),
      .din        (din),
      .delay      (delay),
      .delay_load (delay_load),
`ifdef SAMPLE_DELAY_FRAC_EN
      .delay_frac (delay_frac),
`endif
      .dout       (dout),
      .dout_valid (dout_valid)
   );

   int n_err = 0;
   int n_chk = 0;

   // Model: per-channel history of accepted samples, delay, frac flag, fill count, last output.
   int            hist [CH][$];
   int            md   [CH];
   int            mf   [CH];
   int            mfb  [CH];
   int            last [CH];
   logic [CH-1:0] exp_v;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_clear();
      for (int c = 0; c < CH; c++) begin
         hist[c].delete();
         md[c]   = 0;
         mf[c]   = 0;
         mfb[c]  = 0;
         last[c] = 0;
      end
      exp_v = '0;
   endfunction

   function automatic void model_step();
      int x, n, d;
      if (delay_load) begin
         for (int c = 0; c < CH; c++) begin
            md[c]  = int'(delay[c*AW +: AW]);
`ifdef SAMPLE_DELAY_FRAC_EN
            mf[c]  = int'(delay_frac[c]);
`else
            mf[c]  = 0;
`endif
            mfb[c] = 0;
         end
      end
      exp_v = '0;
      if (din_valid) begin
         for (int c = 0; c < CH; c++) begin
            x = int'($signed(din[c*W +: W]));
            hist[c].push_back(x);
            if (hist[c].size() > DEPTH + 1) void'(hist[c].pop_front());
            n = hist[c].size() - 1;
            d = md[c];
            if (mf[c] != 0 && d != DEPTH - 1) begin
               if (mfb[c] >= d + 1) begin
                  exp_v[c] = 1'b1;
                  last[c]  = (hist[c][n-d] + hist[c][n-d-1]) >>> 1;
               end
            end else if (mfb[c] >= d) begin
               exp_v[c] = 1'b1;
               last[c]  = hist[c][n-d];
            end
            if (mfb[c] < DEPTH - 1) mfb[c]++;
         end
      end
   endfunction

   always @(negedge reset) model_clear();

   always @(posedge clk) begin : monitor
      logic [CH*W-1:0] exp_d;
      if (!reset) model_clear();
      else        model_step();
      for (int c = 0; c < CH; c++) begin
         exp_d[c*W +: W] = last[c][W-1:0];
      end
      #1;
      check("model_dout_valid", {60'd0, dout_valid}, {60'd0, exp_v});
      check("model_dout", dout, exp_d);
   end

   task automatic cyc(input logic v, input logic ld);
      din_valid  = v;
      delay_load = ld;
      @(posedge clk);
      #2;
   endtask

   task automatic set_din(input int c, input int val);
      din[c*W +: W] = val[W-1:0];
   endtask

   task automatic rand_din();
      for (int c = 0; c < CH; c++) din[c*W +: W] = W'($urandom);
   endtask

   task automatic set_delays(input int d0, input int d1, input int d2, input int d3);
      delay = {AW'(d3), AW'(d2), AW'(d1), AW'(d0)};
   endtask

   function automatic int ch_out(input int c);
      return int'($signed(dout[c*W +: W]));
   endfunction

   function automatic int rand_delay();
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) return DEPTH - 1;
      if (r == 1) return DEPTH - 2;
      return int'($urandom_range(0, 12));
   endfunction

   initial begin
      int first0, first3;
      reset      = 1'b0;
      din_valid  = 1'b0;
      delay_load = 1'b0;
      din        = '0;
      delay      = '0;
`ifdef SAMPLE_DELAY_FRAC_EN
      delay_frac = '0;
`endif
      repeat (2) @(posedge clk);
      #2;
      check("reset_dout", dout, 64'd0);
      check("reset_valid", {60'd0, dout_valid}, 64'd0);
      reset = 1'b1;

      // Basic: all delays 3, ramp input
      set_delays(3, 3, 3, 3);
      cyc(1'b0, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         for (int c = 0; c < CH; c++) set_din(c, k + 1000 * c);
         cyc(1'b1, 1'b0);
         if (k == 3) check("basic_k3_valid", {60'd0, dout_valid}, 64'h0);
         if (k == 4) begin
            check("basic_k4_valid", {60'd0, dout_valid}, 64'hF);
            check("basic_k4_ch0", ch_out(0), 1);
            check("basic_k4_ch3", ch_out(3), 3001);
         end
         if (k == 8) check("basic_k8_ch1", ch_out(1), 1005);
      end

      // Per-channel delays 0,1,5,255 with wrap
      set_delays(0, 1, 5, 255);
      cyc(1'b0, 1'b1);
      first0 = 0;
      first3 = 0;
      for (int k = 1; k <= 600; k++) begin
         rand_din();
         if (k == 1) begin
            first0 = int'($signed(din[0 +: W]));
            first3 = int'($signed(din[3*W +: W]));
         end
         cyc(1'b1, 1'b0);
         if (k == 1) begin
            check("pc_k1_valid", {60'd0, dout_valid}, 64'h1);
            check("pc_k1_ch0", ch_out(0), first0);
         end
         if (k == 255) check("pc_k255_ch3_valid", {63'd0, dout_valid[3]}, 64'd0);
         if (k == 256) begin
            check("pc_k256_ch3_valid", {63'd0, dout_valid[3]}, 64'd1);
            check("pc_k256_ch3", ch_out(3), first3);
         end
      end

      // Gapped input, delay 2
      set_delays(2, 2, 2, 2);
      cyc(1'b0, 1'b1);
      for (int k = 0; k < 30; k++) begin
         rand_din();
         set_din(0, k + 7);
         cyc((k % 3) == 0, 1'b0);
         if (k == 4) check("gap_idle_valid", {60'd0, dout_valid}, 64'h0);
         if (k == 6) begin
            check("gap_k6_valid", {60'd0, dout_valid}, 64'hF);
            check("gap_k6_ch0", ch_out(0), 7);
         end
      end

      // Reload mid-stream 3 -> 1 on ch0, coincident with a sample
      set_delays(3, 3, 3, 3);
      cyc(1'b0, 1'b1);
      for (int k = 1; k <= 10; k++) begin
         for (int c = 0; c < CH; c++) set_din(c, 50 + k + 100 * c);
         if (k == 7) set_delays(1, 3, 3, 3);
         cyc(1'b1, k == 7);
         if (k == 7) check("reload_k7_valid", {60'd0, dout_valid}, 64'h0);
         if (k == 8) begin
            check("reload_k8_valid", {60'd0, dout_valid}, 64'h1);
            check("reload_k8_ch0", ch_out(0), 57);
         end
         if (k == 10) begin
            check("reload_k10_valid", {60'd0, dout_valid}, 64'hF);
            check("reload_k10_ch1", ch_out(1), 157);
         end
      end

      // Randomized traffic with occasional reloads
      for (int i = 0; i < 2500; i++) begin
         logic ld;
         rand_din();
         ld = ($urandom_range(0, 49) == 0);
         if (ld) begin
            set_delays(rand_delay(), rand_delay(), rand_delay(), rand_delay());
`ifdef SAMPLE_DELAY_FRAC_EN
            delay_frac = CH'($urandom);
`endif
         end
         cyc($urandom_range(0, 3) != 0, ld);
      end

      // Asynchronous reset between edges
      for (int k = 0; k < 5; k++) begin
         rand_din();
         cyc(1'b1, 1'b0);
      end
      #1 reset = 1'b0;
      #1;
      check("areset_dout", dout, 64'd0);
      check("areset_valid", {60'd0, dout_valid}, 64'd0);
      reset = 1'b1;
`ifdef SAMPLE_DELAY_FRAC_EN
      delay_frac = '0;
`endif
      set_delays(3, 3, 3, 3);
      cyc(1'b0, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         for (int c = 0; c < CH; c++) set_din(c, 20 + k + 10 * c);
         cyc(1'b1, 1'b0);
         if (k == 3) check("areset_k3_valid", {60'd0, dout_valid}, 64'h0);
         if (k == 4) begin
            check("areset_k4_valid", {60'd0, dout_valid}, 64'hF);
            check("areset_k4_ch2", ch_out(2), 41);
         end
      end

`ifdef SAMPLE_DELAY_FRAC_EN
      // Half-sample interpolation with floor rounding
      set_delays(1, 1, 1, 1);
      delay_frac = 4'b0001;
      cyc(1'b0, 1'b1);
      for (int k = 1; k <= 5; k++) begin
         int seq [5] = '{100, 200, -50, -51, 0};
         rand_din();
         set_din(0, seq[k-1]);
         cyc(1'b1, 1'b0);
         if (k == 2) check("frac_k2_valid", {63'd0, dout_valid[0]}, 64'd0);
         if (k == 3) check("frac_k3_ch0", ch_out(0), 150);
         if (k == 4) check("frac_k4_ch0", ch_out(0), 75);
         if (k == 5) check("frac_k5_ch0", ch_out(0), -51);
      end
      delay_frac = '0;
`endif

      cyc(1'b0, 1'b0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
